regfile_wb_sched: RTL and testbench

- Sequences the single write port of the 32x32 MIPS register file.
- Arbitrates NREQ writeback sources (ALU, load unit, mult/div) onto wr_en/wr_addr/wr_data with round-robin fairness.
- Keeps a per-register busy scoreboard for long-latency destinations and raises stall for RAW/WAW hazards at issue.
- Sits between the execute/memory stages and the register file, which samples wr_en as RegWrite on the next clk edge.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_wb_sched_rr_arbiter.sv | 52 +++++
 rtl/regfile_wb_sched.sv | 102 ++++++++++
 tb/tb_regfile_wb_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback scheduler slice.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a rotating start pointer that
// advances past the last winner. Reusable for any shared single port.
module rr_arbiter #(
  parameter int  NREQ  = 3,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop/ifs can leave a value held (which would infer a latch).
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!rst && !gnt_valid_o && req_i[idx]) begin
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = IDX_W'(idx);
        gnt_valid_o = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (int'(gnt_idx_o) == NREQ - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous to match the rest of the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: round-robin writeback arbitration plus a
// busy scoreboard that stalls issue on RAW/WAW against long-latency results.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic                   issue_long,
  input  logic [ADDR_W-1:0]      issue_dst,
  input  logic [ADDR_W-1:0]      chk_rs,
  input  logic [ADDR_W-1:0]      chk_rt,
  output logic                   stall,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int NUM_R = 2 ** ADDR_W;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  logic [NUM_R-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic [NUM_R-1:0] set_vec, clr_vec;
  logic             raw, waw, accept, set_en, inc, dec;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .gnt_o       (req_ready),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (gnt_valid) begin
      wr_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      wr_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // r0 writebacks are consumed by the grant but never reach the register file.
  assign wr_en = gnt_valid && (wr_addr != ZERO_A);

  assign raw    = ((chk_rs != ZERO_A) && busy_q[chk_rs]) ||
                  ((chk_rt != ZERO_A) && busy_q[chk_rt]);
  assign waw    = issue_we && (issue_dst != ZERO_A) && busy_q[issue_dst];
  assign stall  = rst || (issue_valid && (raw || waw));
  assign accept = issue_valid && !stall;
  assign set_en = accept && issue_we && issue_long && (issue_dst != ZERO_A);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[issue_dst] = 1'b1;
    if (wr_en)  clr_vec[wr_addr]   = 1'b1;
    // Set is applied after clear so a same-cycle set/clear leaves the bit 1.
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    inc   = set_en && !busy_q[issue_dst];
    dec   = wr_en && busy_q[wr_addr] && !(set_en && (issue_dst == wr_addr));
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

  // Requesters must hold req_valid until granted.
  for (genvar g = 0; g < NREQ; g++) begin : g_hold_chk
    a_hold_valid : assert property (@(posedge clk) disable iff (rst)
      (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared each cycle against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_sched;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            issue_valid, issue_we, issue_long;
  logic [AW-1:0]   issue_dst, chk_rs, chk_rt;
  logic            stall;
  logic [31:0]     busy_vec;
  logic [AW:0]     busy_cnt;

  regfile_wb_sched #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_long  (issue_long),
    .issue_dst   (issue_dst),
    .chk_rs      (chk_rs),
    .chk_rt      (chk_rt),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .busy_cnt    (busy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_busy [32];
  int          m_rr;
  int          last_gnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // One clock: compare outputs at the negedge, then advance the model at the posedge.
  task automatic step();
    int            g;
    logic [31:0]   exp_busy;
    int            exp_cnt;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    bit            raw, waw, exp_stall, accept;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
    end
    ga = (g >= 0) ? addr_of(g) : '0;
    gd = (g >= 0) ? data_of(g) : '0;
    raw = (chk_rs != 0 && m_busy[chk_rs]) || (chk_rt != 0 && m_busy[chk_rt]);
    waw = issue_we && issue_dst != 0 && m_busy[issue_dst];
    exp_stall = rst || (issue_valid && (raw || waw));
    accept = issue_valid && !exp_stall;
    exp_busy = '0;
    exp_cnt  = 0;
    for (int r = 0; r < 32; r++) begin
      exp_busy[r] = m_busy[r];
      exp_cnt += int'(m_busy[r]);
    end
    check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    check("wr_en",     64'(wr_en),     64'(g >= 0 && ga != 0));
    check("wr_addr",   64'(wr_addr),   64'(ga));
    check("wr_data",   64'(wr_data),   64'(gd));
    check("stall",     64'(stall),     64'(exp_stall));
    check("busy_vec",  64'(busy_vec),  64'(exp_busy));
    check("busy_cnt",  64'(busy_cnt),  64'(exp_cnt));
    @(posedge clk);
    last_gnt = g;
    if (rst) begin
      foreach (m_busy[r]) m_busy[r] = 1'b0;
      m_rr = 0;
    end else begin
      if (g >= 0) begin
        m_rr = (g + 1) % NREQ;
        if (ga != 0) m_busy[ga] = 1'b0;
      end
      if (accept && issue_we && issue_long && issue_dst != 0) m_busy[issue_dst] = 1'b1;
    end
    #1;
  endtask

  task automatic drop_granted();
    if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic set_issue(input bit v, input bit we, input bit lg,
                           input int dst, input int rs, input int rt);
    issue_valid = v;
    issue_we    = we;
    issue_long  = lg;
    issue_dst   = AW'(dst);
    chk_rs      = AW'(rs);
    chk_rt      = AW'(rt);
  endtask

  task automatic drain();
    for (int n = 0; n < 8 && req_valid != 0; n++) begin
      step();
      drop_granted();
    end
    check("drain_done", 64'(req_valid), 64'd0);
  endtask

  initial begin
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_rr = 0;
    last_gnt = -1;
    rst = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    set_issue(0, 0, 0, 0, 0, 0);

    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    step();

    // Round-robin with all three requesters held.
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);
    for (int n = 0; n < 4; n++) step();
    drain();

    // RAW against a long-latency destination.
    set_issue(1, 1, 1, 8, 0, 0);
    step();
    set_issue(1, 0, 0, 0, 8, 0);
    step();
    set_req(2, 5'd8, 32'hDEAD_BEEF);
    step();
    drop_granted();
    step();
    set_issue(0, 0, 0, 0, 0, 0);

    // r0 destination and writeback.
    set_issue(1, 1, 1, 0, 0, 0);
    step();
    set_req(0, 5'd0, 32'h1234_5678);
    set_issue(1, 0, 0, 0, 0, 0);
    step();
    drop_granted();
    step();

    // WAW on a busy destination.
    set_issue(1, 1, 1, 9, 0, 0);
    step();
    set_issue(1, 1, 0, 9, 1, 2);
    step();
    step();
    set_req(1, 5'd9, 32'h0000_0909);
    step();
    drop_granted();
    step();
    set_issue(0, 0, 0, 0, 0, 0);

    // Reset mid-stream with busy registers and pending requests.
    set_issue(1, 1, 1, 5, 0, 0);
    step();
    set_issue(1, 1, 1, 6, 0, 0);
    step();
    set_issue(0, 0, 0, 0, 0, 0);
    set_req(0, 5'd10, 32'h10);
    set_req(1, 5'd11, 32'h11);
    set_req(2, 5'd12, 32'h12);
    step();
    drop_granted();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '1;
    drain();

    // Random traffic; requesters obey the hold-until-granted contract.
    for (int n = 0; n < 600; n++) begin
      drop_granted();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, AW'($urandom_range(0, 9)), $urandom);
      end
      set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9),
                $urandom_range(0, 9), $urandom_range(0, 9));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
